pixel_bus_responder: RTL and testbench

PIXEL_BUS_RESPONDER -- requirements
Module: pixel_bus_responder

---
 rtl/pixel_bus_if.sv | 25 ++
 rtl/pixel_bus_responder.sv | 148 ++++++++++++++
 tb/tb_pixel_bus_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_bus_if.sv
// Requester-side pixel bus: level read/write requests with done/error status and RGB return data.
interface pixel_bus_if;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned RGB_W  = 24;

    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] address;
    logic [PIX_W-1:0]  write_data;
    logic [RGB_W-1:0]  rgb;
    logic              read_done;
    logic              write_done;
    logic              rw_error;

    modport master (
        output read_en, write_en, address, write_data,
        input  rgb, read_done, write_done, rw_error
    );

    modport slave (
        input  read_en, write_en, address, write_data,
        output rgb, read_done, write_done, rw_error
    );
endinterface

// File: rtl/pixel_bus_responder.sv
// Bridges 4-phase pixel read/write requests onto a fixed-latency frame-buffer SRAM port.
// Define RW_ERROR_CHECK_EN to reject out-of-frame addresses with rw_error.
module pixel_bus_responder #(
    parameter int unsigned IMG_PIXELS = 307200,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    pixel_bus_if.slave  bus,
    output logic [18:0] sram_addr,
    output logic        sram_re,
    output logic        sram_we,
    output logic [23:0] sram_wdata,
    input  logic [23:0] sram_rdata
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned RGB_W  = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR      = 3'd3,
        WR_DONE = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               read_done_q, read_done_d;
    logic               write_done_q, write_done_d;
    logic               rw_error_q, rw_error_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic               sram_re_q, sram_re_d;
    logic               sram_we_q, sram_we_d;
    logic [RGB_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic               addr_bad_c;

`ifdef RW_ERROR_CHECK_EN
    assign addr_bad_c = (32'(bus.address) >= IMG_PIXELS);
`else
    assign addr_bad_c = 1'b0;
`endif

    // The SRAM address/data registers double as the request latch while away from IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rgb_d        = rgb_q;
        read_done_d  = 1'b0;
        write_done_d = 1'b0;
        rw_error_d   = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_re_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.read_en) begin
                    if (addr_bad_c) begin
                        state_d    = ERR;
                        rw_error_d = 1'b1;
                    end else begin
                        state_d     = RD_WAIT;
                        sram_re_d   = 1'b1;
                        sram_addr_d = bus.address;
                        cnt_d       = CNT_W'(RD_LAT);
                    end
                end else if (bus.write_en) begin
                    if (addr_bad_c) begin
                        state_d    = ERR;
                        rw_error_d = 1'b1;
                    end else begin
                        state_d      = WR;
                        sram_we_d    = 1'b1;
                        sram_addr_d  = bus.address;
                        sram_wdata_d = {3{bus.write_data}};
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d     = RD_DONE;
                    cnt_d       = '0;
                    rgb_d       = sram_rdata;
                    read_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_DONE: begin
                if (bus.read_en) read_done_d = 1'b1;
                else             state_d     = IDLE;
            end
            WR: begin
                state_d      = WR_DONE;
                write_done_d = 1'b1;
            end
            WR_DONE: begin
                if (bus.write_en) write_done_d = 1'b1;
                else              state_d      = IDLE;
            end
            ERR: begin
                if (bus.read_en || bus.write_en) rw_error_d = 1'b1;
                else                             state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rgb_q        <= '0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            rw_error_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_re_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rgb_q        <= rgb_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
            rw_error_q   <= rw_error_d;
            sram_addr_q  <= sram_addr_d;
            sram_re_q    <= sram_re_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.read_done  = read_done_q;
    assign bus.write_done = write_done_q;
    assign bus.rw_error   = rw_error_q;
    assign sram_addr      = sram_addr_q;
    assign sram_re        = sram_re_q;
    assign sram_we        = sram_we_q;
    assign sram_wdata     = sram_wdata_q;
endmodule

// File: tb/tb_pixel_bus_responder.sv
// Self-checking bench for pixel_bus_responder: directed table, corner sequences and random traffic.
module tb_pixel_bus_responder;
    localparam int unsigned IMG_PIXELS = 307200;
    localparam int unsigned RD_LAT     = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [18:0] sram_addr;
    logic        sram_re;
    logic        sram_we;
    logic [23:0] sram_wdata;
    logic [23:0] sram_rdata;

    pixel_bus_if bus();

    pixel_bus_responder #(.IMG_PIXELS(IMG_PIXELS), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-buffer model: data is valid from the cycle after sram_re and held.
    logic [23:0] sram_mem [int];
    function automatic logic [23:0] init_val(int a);
        return 24'(a * 32'h0001_0307 + 32'h11);
    endfunction
    function automatic logic [23:0] sram_peek(int a);
        return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
    endfunction
    always @(posedge clk) begin
        if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
        if (sram_re) sram_rdata <= sram_peek(int'(sram_addr));
    end

    int re_cnt = 0, we_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (sram_re) re_cnt++;
        if (sram_we) we_cnt++;
        if (sram_re && sram_we) both_cnt++;
    end

    // Reference contents as the requester expects them to be.
    logic [23:0] ref_mem [int];
    function automatic logic [23:0] ref_read(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [18:0] a, input logic [23:0] exp, input string tag);
        int re0;
        int n;
        re0 = re_cnt;
        bus.read_en = 1'b1;
        bus.address = a;
        tick();
        n = 1;
        chk($sformatf("%s_re", tag), 32'(sram_re), 32'd1);
        chk($sformatf("%s_addr", tag), 32'(sram_addr), 32'(a));
        bus.address = ~a;
        while (!bus.read_done && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s_latency", tag), 32'(n), 32'(RD_LAT + 1));
        chk($sformatf("%s_rgb", tag), 32'(bus.rgb), 32'(exp));
        chk($sformatf("%s_re_pulses", tag), 32'(re_cnt - re0), 32'd1);
        tick();
        chk($sformatf("%s_done_held", tag), 32'(bus.read_done), 32'd1);
        bus.read_en = 1'b0;
        tick();
        chk($sformatf("%s_done_drop", tag), 32'(bus.read_done), 32'd0);
        chk($sformatf("%s_rgb_kept", tag), 32'(bus.rgb), 32'(exp));
    endtask

    task automatic do_write(input logic [18:0] a, input logic [7:0] wd,
                            input logic [23:0] exp, input string tag);
        int we0;
        we0 = we_cnt;
        bus.write_en   = 1'b1;
        bus.address    = a;
        bus.write_data = wd;
        tick();
        chk($sformatf("%s_we", tag), 32'(sram_we), 32'd1);
        chk($sformatf("%s_re", tag), 32'(sram_re), 32'd0);
        chk($sformatf("%s_addr", tag), 32'(sram_addr), 32'(a));
        chk($sformatf("%s_wdata", tag), 32'(sram_wdata), 32'(exp));
        bus.address    = ~a;
        bus.write_data = ~wd;
        tick();
        chk($sformatf("%s_done", tag), 32'(bus.write_done), 32'd1);
        chk($sformatf("%s_we_drop", tag), 32'(sram_we), 32'd0);
        tick();
        chk($sformatf("%s_done_held", tag), 32'(bus.write_done), 32'd1);
        bus.write_en = 1'b0;
        tick();
        chk($sformatf("%s_done_drop", tag), 32'(bus.write_done), 32'd0);
        chk($sformatf("%s_we_pulses", tag), 32'(we_cnt - we0), 32'd1);
        ref_mem[int'(a)] = {wd, wd, wd};
    endtask

    typedef struct {
        bit          wr;
        logic [18:0] addr;
        logic [7:0]  wd;
        logic [23:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int   n;
        int   seen;
        int   re0, we0;

        tbl[0] = '{1'b0, 19'd5,              8'h00, 24'hA1B2C3};
        tbl[1] = '{1'b1, 19'd100,            8'h7F, 24'h7F7F7F};
        tbl[2] = '{1'b0, 19'd100,            8'h00, 24'h7F7F7F};
        tbl[3] = '{1'b1, 19'd0,              8'h00, 24'h000000};
        tbl[4] = '{1'b0, 19'd0,              8'h00, 24'h000000};
        tbl[5] = '{1'b1, 19'(IMG_PIXELS - 1), 8'hA5, 24'hA5A5A5};
        tbl[6] = '{1'b0, 19'(IMG_PIXELS - 1), 8'h00, 24'hA5A5A5};

        sram_mem[5] = 24'hA1B2C3;
        ref_mem[5]  = 24'hA1B2C3;

        bus.read_en    = 1'b0;
        bus.write_en   = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;

        // Reset values
        tick();
        tick();
        chk("rst_rgb", 32'(bus.rgb), 32'd0);
        chk("rst_read_done", 32'(bus.read_done), 32'd0);
        chk("rst_write_done", 32'(bus.write_done), 32'd0);
        chk("rst_rw_error", 32'(bus.rw_error), 32'd0);
        chk("rst_sram_ctl", 32'({sram_re, sram_we}), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d_wr", i));
            else           do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd", i));
        end

        // Simultaneous requests: read first, then the write on a later IDLE visit
        bus.read_en    = 1'b1;
        bus.write_en   = 1'b1;
        bus.address    = 19'd7;
        bus.write_data = 8'h3C;
        tick();
        chk("both_re_first", 32'({sram_re, sram_we}), 32'b10);
        n = 1;
        while (!bus.read_done && n < 20) begin
            tick();
            n++;
        end
        chk("both_rd_latency", 32'(n), 32'(RD_LAT + 1));
        chk("both_rd_rgb", 32'(bus.rgb), 32'(ref_read(7)));
        bus.read_en = 1'b0;
        tick();
        chk("both_rd_drop", 32'({bus.read_done, sram_we}), 32'd0);
        tick();
        chk("both_wr_we", 32'(sram_we), 32'd1);
        chk("both_wr_addr", 32'(sram_addr), 32'd7);
        chk("both_wr_wdata", 32'(sram_wdata), 32'h3C3C3C);
        tick();
        chk("both_wr_done", 32'(bus.write_done), 32'd1);
        bus.write_en = 1'b0;
        tick();
        chk("both_wr_drop", 32'(bus.write_done), 32'd0);
        ref_mem[7] = 24'h3C3C3C;
        do_read(19'd7, 24'h3C3C3C, "both_readback");

        // Address just past the frame
`ifdef RW_ERROR_CHECK_EN
        re0 = re_cnt;
        bus.read_en = 1'b1;
        bus.address = 19'(IMG_PIXELS);
        tick();
        chk("oob_err", 32'(bus.rw_error), 32'd1);
        tick();
        tick();
        chk("oob_err_held", 32'(bus.rw_error), 32'd1);
        chk("oob_no_re", 32'(re_cnt - re0), 32'd0);
        bus.read_en = 1'b0;
        tick();
        chk("oob_err_drop", 32'(bus.rw_error), 32'd0);
        do_read(19'd5, 24'hA1B2C3, "oob_recover");
`else
        do_read(19'(IMG_PIXELS), ref_read(int'(IMG_PIXELS)), "oob_read");
        chk("oob_no_err", 32'(bus.rw_error), 32'd0);
`endif

        // Reset in the middle of a read
        bus.read_en = 1'b1;
        bus.address = 19'd100;
        tick();
        n_rst = 1'b0;
        #1;
        chk("mid_rst_sram", 32'({sram_re, sram_we}), 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_wdata", 32'(sram_wdata), 32'd0);
        chk("mid_rst_rgb", 32'(bus.rgb), 32'd0);
        chk("mid_rst_status", 32'({bus.read_done, bus.write_done, bus.rw_error}), 32'd0);
        bus.read_en = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        we0 = we_cnt;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.read_done) seen++;
        end
        chk("post_rst_no_done", 32'(seen), 32'd0);
        chk("post_rst_rgb", 32'(bus.rgb), 32'd0);
        chk("post_rst_no_we", 32'(we_cnt - we0), 32'd0);

        // Random traffic against the reference contents
        for (int i = 0; i < 40; i++) begin
            logic [18:0] a;
            logic [7:0]  wd;
            a  = 19'($urandom_range(0, 31));
            wd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, wd, {wd, wd, wd}, $sformatf("rnd%0d_wr", i));
            else                           do_read(a, ref_read(int'(a)), $sformatf("rnd%0d_rd", i));
        end

        chk("never_re_and_we", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got %0d vectors expected completion", vectors);
        $fatal(1);
    end
endmodule
